// File: rtl/axis_sync_fifo_ram.sv
// Storage for axis_sync_fifo: one synchronous write port, one asynchronous read port.
// Contents are never reset; the owner gates the read data when the entries are stale.
module axis_sync_fifo_ram #(
  parameter int DATA_WIDTH = 32,
  parameter int FIFO_LEN   = 16
) (
  input  logic                        i_clk,
  input  logic                        i_wr_en,
  input  logic [$clog2(FIFO_LEN)-1:0] i_wr_addr,
  input  logic [DATA_WIDTH-1:0]       i_wr_dat,
  input  logic [$clog2(FIFO_LEN)-1:0] i_rd_addr,
  output logic [DATA_WIDTH-1:0]       o_rd_dat
);

  logic [DATA_WIDTH-1:0] r_mem [FIFO_LEN];

  always_ff @(posedge i_clk) begin
    if (i_wr_en) begin
      r_mem[i_wr_addr] <= i_wr_dat;
    end
  end

  assign o_rd_dat = r_mem[i_rd_addr];

endmodule

// File: rtl/axis_sync_fifo.sv
// First-word-fall-through AXI-Stream FIFO, one cycle input to output; tready/tvalid come only from registered pointers.
// Optional sticky overflow_o (write attempted while full) under AXIS_SYNC_FIFO_OVERFLOW_EN.
module axis_sync_fifo #(
  parameter int DATA_WIDTH = 32,
  parameter int FIFO_LEN   = 16
) (
  input  logic                        clk_i,
  input  logic                        reset_i,
  input  logic [DATA_WIDTH-1:0]       s_axis_in_tdata,
  input  logic                        s_axis_in_tvalid,
  output logic                        s_axis_in_tready,
  output logic [DATA_WIDTH-1:0]       m_axis_out_tdata,
  output logic                        m_axis_out_tvalid,
  input  logic                        m_axis_out_tready,
  output logic [$clog2(FIFO_LEN):0]   level_o,
  output logic                        empty_o,
`ifdef AXIS_SYNC_FIFO_OVERFLOW_EN
  output logic                        full_o,
  output logic                        overflow_o
`else
  output logic                        full_o
`endif
);

  localparam int AW = $clog2(FIFO_LEN);
  localparam int PW = AW + 1;

  if (FIFO_LEN < 2 || (FIFO_LEN & (FIFO_LEN - 1)) != 0) begin : g_bad_len
    $error("axis_sync_fifo: FIFO_LEN must be a power of two and at least 2");
  end

  logic [PW-1:0]         r_wr_ptr;
  logic [PW-1:0]         r_rd_ptr;
  logic [PW-1:0]         r_level;
  logic                  w_empty;
  logic                  w_full;
  logic                  w_wr;
  logic                  w_rd;
  logic [DATA_WIDTH-1:0] w_rd_dat;

  // Extra pointer MSB separates a full lap from an empty FIFO.
  assign w_empty = (r_wr_ptr == r_rd_ptr);
  assign w_full  = (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]) && (r_wr_ptr[AW] != r_rd_ptr[AW]);
  assign w_wr    = s_axis_in_tvalid && !w_full;
  assign w_rd    = m_axis_out_tready && !w_empty;

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else begin
      if (w_wr) r_wr_ptr <= r_wr_ptr + PW'(1);
      if (w_rd) r_rd_ptr <= r_rd_ptr + PW'(1);
      case ({w_wr, w_rd})
        2'b10:   r_level <= r_level + PW'(1);
        2'b01:   r_level <= r_level - PW'(1);
        default: r_level <= r_level;
      endcase
    end
  end

  axis_sync_fifo_ram #(
    .DATA_WIDTH(DATA_WIDTH),
    .FIFO_LEN  (FIFO_LEN)
  ) u_ram (
    .i_clk    (clk_i),
    .i_wr_en  (w_wr),
    .i_wr_addr(r_wr_ptr[AW-1:0]),
    .i_wr_dat (s_axis_in_tdata),
    .i_rd_addr(r_rd_ptr[AW-1:0]),
    .o_rd_dat (w_rd_dat)
  );

  // Array is unreset, so stale or X contents must not leak out while empty.
  assign m_axis_out_tdata  = w_empty ? '0 : w_rd_dat;
  assign m_axis_out_tvalid = !w_empty;
  assign s_axis_in_tready  = !w_full;
  assign level_o           = r_level;
  assign empty_o           = w_empty;
  assign full_o            = w_full;

`ifdef AXIS_SYNC_FIFO_OVERFLOW_EN
  logic r_overflow;

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      r_overflow <= 1'b0;
    end else if (s_axis_in_tvalid && w_full) begin
      r_overflow <= 1'b1;
    end
  end

  assign overflow_o = r_overflow;
`endif

endmodule

// File: tb/tb_axis_sync_fifo.sv
// Randomised and directed bench for axis_sync_fifo against a queue-based reference model.
module tb_axis_sync_fifo;
  localparam int DW  = 32;
  localparam int LEN = 16;

  logic          clk_i = 1'b0;
  logic          reset_i;
  logic [DW-1:0] s_tdata;
  logic          s_tvalid;
  logic          s_tready;
  logic [DW-1:0] m_tdata;
  logic          m_tvalid;
  logic          m_tready;
  logic [4:0]    level_o;
  logic          empty_o;
  logic          full_o;
  logic          ovf;

  always #5 clk_i = ~clk_i;

  axis_sync_fifo #(.DATA_WIDTH(DW), .FIFO_LEN(LEN)) dut (
    .clk_i            (clk_i),
    .reset_i          (reset_i),
    .s_axis_in_tdata  (s_tdata),
    .s_axis_in_tvalid (s_tvalid),
    .s_axis_in_tready (s_tready),
    .m_axis_out_tdata (m_tdata),
    .m_axis_out_tvalid(m_tvalid),
    .m_axis_out_tready(m_tready),
    .level_o          (level_o),
    .empty_o          (empty_o),
`ifdef AXIS_SYNC_FIFO_OVERFLOW_EN
    .full_o           (full_o),
    .overflow_o       (ovf)
`else
    .full_o           (full_o)
`endif
  );

`ifndef AXIS_SYNC_FIFO_OVERFLOW_EN
  assign ovf = 1'b0;
`endif

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  // Reference model: the FIFO is just a queue of accepted words.
  logic [DW-1:0] q[$];
  bit            ovf_m;
  bit            m_wr, m_rd;
  int            n_wr, n_rd;

  always @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      q.delete();
      ovf_m = 1'b0;
    end else begin
      m_wr = s_tvalid && (q.size() < LEN);
      m_rd = m_tready && (q.size() > 0);
      if (s_tvalid && q.size() == LEN) ovf_m = 1'b1;
      if (m_rd) begin
        void'(q.pop_front());
        n_rd++;
      end
      if (m_wr) begin
        q.push_back(s_tdata);
        n_wr++;
      end
    end
  end

  bit cmp_en = 1'b0;

  always @(negedge clk_i) begin
    if (cmp_en && !reset_i) begin
      check("level", level_o, q.size());
      check("empty", empty_o, q.size() == 0);
      check("full", full_o, q.size() == LEN);
      check("s_tready", s_tready, q.size() != LEN);
      check("m_tvalid", m_tvalid, q.size() != 0);
      check("m_tdata", m_tdata, (q.size() != 0) ? q[0] : '0);
`ifdef AXIS_SYNC_FIFO_OVERFLOW_EN
      check("overflow", ovf, ovf_m);
`endif
    end
  end

  // Inputs change 1 time unit after the rising edge, then the next edge is consumed.
  task automatic step(input logic v, input logic [DW-1:0] d, input logic r);
    s_tvalid = v;
    s_tdata  = d;
    m_tready = r;
    @(posedge clk_i);
    #1;
  endtask

  initial begin
    int cyc;
    reset_i  = 1'b1;
    s_tvalid = 1'b0;
    s_tdata  = '0;
    m_tready = 1'b0;
    n_wr = 0;
    n_rd = 0;
    repeat (2) @(posedge clk_i);
    #1;
    check("rst_level", level_o, 0);
    check("rst_empty", empty_o, 1);
    check("rst_tready", s_tready, 1);
    check("rst_tvalid", m_tvalid, 0);
    check("rst_tdata", m_tdata, 0);
    reset_i = 1'b0;
    cmp_en  = 1'b1;

    // Fill 1..16 with the sink stalled, then drain in order.
    for (int i = 1; i <= LEN; i++) step(1'b1, DW'(i), 1'b0);
    s_tvalid = 1'b0;
    check("fill_level", level_o, 16);
    check("fill_full", full_o, 1);
    check("fill_tready", s_tready, 0);
    for (int i = 1; i <= LEN; i++) begin
      check("drain_word", m_tdata, i);
      step(1'b0, '0, 1'b1);
    end
    check("drain_empty", empty_o, 1);

    // One-cycle pass-through from an empty FIFO.
    step(1'b1, 32'hDEADBEEF, 1'b1);
    check("pt_tvalid", m_tvalid, 1);
    check("pt_tdata", m_tdata, 32'hDEADBEEF);
    check("pt_level", level_o, 1);
    step(1'b0, '0, 1'b1);
    check("pt_empty", empty_o, 1);
    check("pt_level0", level_o, 0);

    // Full with a pending write: the read wins this cycle, the write lands next cycle.
    for (int i = 1; i <= LEN; i++) step(1'b1, DW'(32'h100 + i), 1'b0);
    step(1'b1, 32'h11, 1'b1);
    check("fwr_level15", level_o, 15);
    check("fwr_head", m_tdata, 32'h102);
`ifdef AXIS_SYNC_FIFO_OVERFLOW_EN
    check("ovf_set", ovf, 1);
`endif
    step(1'b1, 32'h11, 1'b0);
    check("fwr_level16", level_o, 16);
    s_tvalid = 1'b0;
    for (int i = 0; i < LEN - 1; i++) step(1'b0, '0, 1'b1);
    check("fwr_tail", m_tdata, 32'h11);
    step(1'b0, '0, 1'b1);
    check("fwr_empty", empty_o, 1);
`ifdef AXIS_SYNC_FIFO_OVERFLOW_EN
    check("ovf_sticky", ovf, 1);
`endif

    // Asynchronous reset with 5 words stored, checked before the next edge.
    for (int i = 0; i < 5; i++) step(1'b1, DW'(32'hA0 + i), 1'b0);
    s_tvalid = 1'b0;
    check("pre_rst_level", level_o, 5);
    reset_i = 1'b1;
    #1;
    check("arst_level", level_o, 0);
    check("arst_empty", empty_o, 1);
    check("arst_full", full_o, 0);
    check("arst_tvalid", m_tvalid, 0);
    check("arst_tready", s_tready, 1);
    check("arst_tdata", m_tdata, 0);
    check("arst_ovf", ovf, 0);
    @(posedge clk_i);
    #1;
    reset_i = 1'b0;

    // Random traffic: 100 accepted words, roughly 50% valid and ready.
    n_wr = 0;
    n_rd = 0;
    cyc  = 0;
    while (n_wr < 100 && cyc < 5000) begin
      step(1'($urandom_range(0, 1)), $urandom, 1'($urandom_range(0, 1)));
      if (level_o > 5'd16) check("rand_level_range", level_o, 16);
      cyc++;
    end
    check("rand_budget", n_wr >= 100, 1);
    s_tvalid = 1'b0;
    for (int i = 0; i < 2 * LEN; i++) step(1'b0, '0, 1'b1);
    check("rand_empty", empty_o, 1);
    check("rand_count", n_rd, n_wr);

    cmp_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
